reg_cmd_ctrl: RTL and testbench

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

---
 rtl/reg_cmd_ctrl_if.sv | 26 ++
 rtl/reg_cmd_ctrl.sv | 89 ++++++++
 tb/tb_reg_cmd_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_cmd_ctrl_if.sv
// reg_cmd_ctrl_if: UART byte stream, register-file and transmitter signals of the command controller
interface reg_cmd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [WIDTH-1:0] RX_P_DATA;
  logic RX_D_VLD;
  logic [WIDTH-1:0] RdData;
  logic RdData_Valid;
  logic TX_BUSY;
  logic WrEn;
  logic RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] TX_P_DATA;
  logic TX_D_VLD;
  logic CMD_ERR;
  modport master (
    input RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    input WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: decodes UART command frames into register-file writes/reads and returns read data to the transmitter
module reg_cmd_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT = 1024
) (
  input logic CLK,
  input logic RST,
  reg_cmd_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic rx, tmo, addr_ok;
  always_comb begin
    rx = bus.RX_D_VLD;
    tmo = cnt == CW'(TIMEOUT - 1);
    addr_ok = (bus.RX_P_DATA >> ADDR_WIDTH) == '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      bus.WrEn <= 1'b0;
      bus.RdEn <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      bus.CMD_ERR <= 1'b0;
      bus.Address <= '0;
      bus.WrData <= '0;
      bus.TX_P_DATA <= '0;
    end else begin
      bus.WrEn <= 1'b0;
      bus.RdEn <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      bus.CMD_ERR <= 1'b0;
      cnt <= (rx || state == IDLE || state == TX_WAIT) ? '0 : cnt + 1'b1;
      // a byte arriving on the timeout cycle takes priority over the abort
      case (state)
        IDLE:
          if (rx) begin
            if (bus.RX_P_DATA == WIDTH'(8'hAA)) state <= WR_ADDR;
            else if (bus.RX_P_DATA == WIDTH'(8'hBB)) state <= RD_ADDR;
            else bus.CMD_ERR <= 1'b1;
          end
        WR_ADDR, RD_ADDR:
          if (rx) begin
            if (!addr_ok) begin
              bus.CMD_ERR <= 1'b1;
              state <= IDLE;
            end else begin
              bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
              bus.RdEn <= state == RD_ADDR;
              state <= state == WR_ADDR ? WR_DATA : RD_WAIT;
            end
          end else if (tmo) begin
            bus.CMD_ERR <= 1'b1;
            state <= IDLE;
            cnt <= '0;
          end
        WR_DATA:
          if (rx) begin
            bus.WrData <= bus.RX_P_DATA;
            bus.WrEn <= 1'b1;
            state <= IDLE;
          end else if (tmo) begin
            bus.CMD_ERR <= 1'b1;
            state <= IDLE;
            cnt <= '0;
          end
        RD_WAIT:
          if (bus.RdData_Valid) begin
            bus.TX_P_DATA <= bus.RdData;
            state <= TX_WAIT;
          end else if (tmo) begin
            bus.CMD_ERR <= 1'b1;
            state <= IDLE;
            cnt <= '0;
          end
        TX_WAIT:
          if (!bus.TX_BUSY) begin
            bus.TX_D_VLD <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: directed frames with hand-computed expectations against reg_cmd_ctrl
module tb_reg_cmd_ctrl;
  localparam int T = 32;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int total = 0;
  int bad = 0;
  int both = 0;
  int hits;
  reg_cmd_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();
  reg_cmd_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(T)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (bus.WrEn && bus.RdEn) both++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD = 1'b1;
    tick();
    bus.RX_D_VLD = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CMD_ERR, bus.Address, bus.WrData, bus.TX_P_DATA}, 0);
  endtask
  initial begin
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD = 1'b0;
    bus.RdData = '0;
    bus.RdData_Valid = 1'b0;
    bus.TX_BUSY = 1'b0;
    tick();
    tick();
    chk_zero("reset_state");
    RST = 1'b0;
    send(8'hAA);
    send(8'h02);
    chk("wr_early", bus.WrEn, 0);
    send(8'h81);
    chk("wr_pulse", {bus.WrEn, bus.RdEn, bus.Address, bus.WrData}, {2'b10, 4'h2, 8'h81});
    tick();
    chk("wr_one_cycle", bus.WrEn, 0);
    send(8'hBB);
    send(8'h02);
    chk("rd_pulse", {bus.RdEn, bus.WrEn, bus.Address}, {2'b10, 4'h2});
    bus.RdData = 8'h81;
    bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0;
    chk("rd_one_cycle", {bus.RdEn, bus.TX_D_VLD, bus.TX_P_DATA}, {2'b00, 8'h81});
    tick();
    chk("tx_pulse", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h81});
    tick();
    chk("tx_one_cycle", bus.TX_D_VLD, 0);
    bus.TX_BUSY = 1'b1;
    send(8'hBB);
    send(8'h07);
    bus.RdData = 8'h3C;
    bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.TX_D_VLD) hits++;
    end
    chk("tx_busy_hold", hits, 0);
    bus.TX_BUSY = 1'b0;
    tick();
    chk("tx_after_busy", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h3C});
    tick();
    chk("tx_after_busy_end", bus.TX_D_VLD, 0);
    send(8'h5C);
    chk("unknown_err", {bus.CMD_ERR, bus.WrEn, bus.RdEn}, 3'b100);
    tick();
    chk("unknown_err_end", bus.CMD_ERR, 0);
    send(8'hAA);
    send(8'h03);
    send(8'h10);
    chk("wr_reg3", {bus.WrEn, bus.Address, bus.WrData}, {1'b1, 4'h3, 8'h10});
    tick();
    chk("hold_vals", {bus.WrEn, bus.Address, bus.WrData}, {1'b0, 4'h3, 8'h10});
    send(8'hAA);
    send(8'h12);
    chk("bad_addr", {bus.CMD_ERR, bus.WrEn, bus.Address}, {2'b10, 4'h3});
    send(8'h55);
    chk("bad_addr_idle", {bus.CMD_ERR, bus.WrEn}, 2'b10);
    tick();
    send(8'hAA);
    hits = 0;
    for (int i = 0; i < T - 1; i++) begin
      tick();
      if (bus.CMD_ERR) hits++;
    end
    chk("to_quiet", hits, 0);
    tick();
    chk("to_err", bus.CMD_ERR, 1);
    tick();
    send(8'h03);
    chk("to_then_cmd", {bus.CMD_ERR, bus.WrEn}, 2'b10);
    tick();
    send(8'hAA);
    for (int i = 0; i < T - 1; i++) tick();
    send(8'h05);
    chk("race_byte_wins", bus.CMD_ERR, 0);
    send(8'h44);
    chk("race_write", {bus.WrEn, bus.Address, bus.WrData}, {1'b1, 4'h5, 8'h44});
    send(8'hBB);
    send(8'h04);
    hits = 0;
    for (int i = 0; i < T - 1; i++) begin
      tick();
      if (bus.CMD_ERR) hits++;
    end
    chk("rd_to_quiet", hits, 0);
    tick();
    chk("rd_to_err", {bus.CMD_ERR, bus.TX_D_VLD}, 2'b10);
    tick();
    send(8'hBB);
    send(8'h01);
    chk("rst_rd_pulse", bus.RdEn, 1);
    RST = 1'b1;
    tick();
    chk_zero("mid_reset");
    RST = 1'b0;
    bus.RdData = 8'h99;
    bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.TX_D_VLD || bus.CMD_ERR) hits++;
    end
    chk("post_reset_quiet", hits, 0);
    send(8'h03);
    chk("post_reset_cmd", bus.CMD_ERR, 1);
    tick();
    chk("wr_rd_exclusive", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
